// File: rtl/daisychain_master_if.sv
// Host-side request/response handshake bundle for the daisychain bus master.
// The DUT takes the master modport; the host/config logic takes the slave modport.
interface daisychain_master_if #(
  parameter int DATA_LEN = 8,
  parameter int CMD_LEN  = 2
);
  logic                req_valid;
  logic                req_ready;
  logic [CMD_LEN-1:0]  req_op;
  logic [DATA_LEN-1:0] req_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_LEN-1:0] rsp_data;

  modport master (
    input  req_valid, req_op, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

  modport slave (
    output req_valid, req_op, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/daisychain_master.sv
// Daisychain serial-line master: frames host requests as start/command/data on a
// single tri-state wire and collects readback bits into a valid/ready response.
module daisychain_master #(
  parameter int DATA_LEN  = 8,
  parameter int CMD_LEN   = 2,
  parameter int CMD_GAP   = 2,
  parameter int TURN_GAP  = 1,
  parameter int INTER_GAP = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  daisychain_master_if.master  bus,
  output logic                 busy,
  output logic                 line_out,
  output logic                 line_oe,
  input  logic                 line_in
);
  localparam int CW = $clog2(DATA_LEN + 2) + 1;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_CMD  = CW'(CMD_LEN - 1);
  localparam logic [CW-1:0] CNT_GAP  = CW'(CMD_GAP - 1);
  localparam logic [CW-1:0] CNT_WR   = CW'(DATA_LEN);
  localparam logic [CW-1:0] CNT_TURN = CW'(TURN_GAP - 1);
  localparam logic [CW-1:0] CNT_RD   = CW'(DATA_LEN - 1);
  localparam logic [CW-1:0] CNT_HOLD = CW'(INTER_GAP - 1);

  localparam logic [CMD_LEN-1:0] OP_WRITE = CMD_LEN'(2'b10);
  localparam logic [CMD_LEN-1:0] OP_READ  = CMD_LEN'(2'b11);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_START   = 4'd1,
    S_CMD     = 4'd2,
    S_GAP     = 4'd3,
    S_WR_DATA = 4'd4,
    S_TURN    = 4'd5,
    S_RD_DATA = 4'd6,
    S_RESP    = 4'd7,
    S_HOLD    = 4'd8
  } state_t;

  state_t              state_r, state_s;
  logic [CW-1:0]       cnt_r, cnt_s;
  logic [CMD_LEN-1:0]  op_r;
  logic [CMD_LEN-1:0]  cmd_sh_r;
  logic [DATA_LEN-1:0] data_sh_r;
  logic [DATA_LEN-2:0] rd_sh_r;
  logic [DATA_LEN-1:0] rsp_data_r;
  logic                req_ready_r, rsp_valid_r, busy_r;
  logic                line_out_r, line_oe_r;
  logic                line_out_s, line_oe_s;
  logic                accept_s;

  assign accept_s      = (state_r == S_IDLE) && bus.req_valid && req_ready_r;
  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign busy          = busy_r;
  assign line_out      = line_out_r;
  assign line_oe       = line_oe_r;

  // Next-state and phase counter; each timed phase loads its length-1 on entry.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_s = S_START;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_START: begin
        state_s = S_CMD;
        cnt_s   = CNT_CMD;
      end
      S_CMD: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = S_GAP;
          cnt_s   = CNT_GAP;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt_r == CNT_ZERO) begin
          case (op_r)
            OP_WRITE: begin
              state_s = S_WR_DATA;
              cnt_s   = CNT_WR;
            end
            OP_READ: begin
              state_s = S_TURN;
              cnt_s   = CNT_TURN;
            end
            default: begin
              state_s = S_HOLD;
              cnt_s   = CNT_HOLD;
            end
          endcase
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      S_WR_DATA: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = S_HOLD;
          cnt_s   = CNT_HOLD;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      S_TURN: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = S_RD_DATA;
          cnt_s   = CNT_RD;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      S_RD_DATA: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = S_RESP;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_s = S_HOLD;
          cnt_s   = CNT_HOLD;
        end else begin
          state_s = S_RESP;
        end
      end
      S_HOLD: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = S_IDLE;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Line value for the upcoming cycle, derived from the state being entered.
  always_comb begin
    line_out_s = 1'b0;
    line_oe_s  = 1'b1;
    case (state_s)
      S_START:   line_out_s = 1'b1;
      S_CMD:     line_out_s = cmd_sh_r[CMD_LEN-1];
      S_WR_DATA: line_out_s = data_sh_r[DATA_LEN-1];
      S_TURN:    line_oe_s  = 1'b0;
      S_RD_DATA: line_oe_s  = 1'b0;
      default:   line_out_s = 1'b0;
    endcase
  end

  // State, counter and registered status/line outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      cnt_r       <= CNT_ZERO;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      line_out_r  <= 1'b0;
      line_oe_r   <= 1'b1;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      req_ready_r <= (state_s == S_IDLE);
      rsp_valid_r <= (state_s == S_RESP);
      busy_r      <= (state_s != S_IDLE);
      line_out_r  <= line_out_s;
      line_oe_r   <= line_oe_s;
    end
  end

  // Command/payload latches; shifters drain MSB first as bits go on the line,
  // so the WRITE pad cycle naturally sees an all-zero payload register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_r      <= {CMD_LEN{1'b0}};
      cmd_sh_r  <= {CMD_LEN{1'b0}};
      data_sh_r <= {DATA_LEN{1'b0}};
    end else if (accept_s) begin
      op_r      <= bus.req_op;
      cmd_sh_r  <= bus.req_op;
      data_sh_r <= bus.req_data;
    end else begin
      op_r <= op_r;
      if (state_s == S_CMD) begin
        cmd_sh_r <= {cmd_sh_r[CMD_LEN-2:0], 1'b0};
      end else begin
        cmd_sh_r <= cmd_sh_r;
      end
      if (state_s == S_WR_DATA) begin
        data_sh_r <= {data_sh_r[DATA_LEN-2:0], 1'b0};
      end else begin
        data_sh_r <= data_sh_r;
      end
    end
  end

  // Readback capture; rsp_data only changes on the final RD_DATA edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_sh_r    <= {(DATA_LEN-1){1'b0}};
      rsp_data_r <= {DATA_LEN{1'b0}};
    end else if (state_r == S_RD_DATA) begin
      rd_sh_r <= {rd_sh_r[DATA_LEN-3:0], line_in};
      if (cnt_r == CNT_ZERO) begin
        rsp_data_r <= {rd_sh_r, line_in};
      end else begin
        rsp_data_r <= rsp_data_r;
      end
    end else begin
      rd_sh_r    <= rd_sh_r;
      rsp_data_r <= rsp_data_r;
    end
  end
endmodule

// File: tb/tb_daisychain_master.sv
// Directed bench for daisychain_master: a table of whole transactions checked
// cycle by cycle, plus scripted reset, back-pressure and back-to-back sequences.
module tb_daisychain_master;
  logic clk = 1'b0;
  logic reset;
  logic busy, line_out, line_oe, line_in;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] last_rd = 8'h00;

  always #5 clk = ~clk;

  daisychain_master_if #(.DATA_LEN(8), .CMD_LEN(2)) bus ();

  daisychain_master dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .line_out (line_out),
    .line_oe  (line_oe),
    .line_in  (line_in)
  );

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  data;
    logic [7:0]  rd;
    logic [15:0] exp_line;
    logic [15:0] exp_oe;
    int          nbits;
    int          ready_cyc;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("wait_ready_timeout", {31'd0, bus.req_ready}, 32'd1);
  endtask

  // Chain model: readback bit for cycle c of a frame (cycles 7..14).
  function automatic logic rd_bit(input logic [7:0] rd, input int c);
    if (c >= 7 && c <= 14) return rd[14-c];
    else return 1'b0;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [7:0] data);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_data  = data;
    step();
    bus.req_valid = 1'b0;
  endtask

  // Accept a READ and run the chain model through cycle 14; ends in cycle 15.
  task automatic read_cycles(input logic [7:0] rd);
    issue(2'b11, 8'h00);
    for (int c = 1; c <= 14; c++) begin
      line_in = rd_bit(rd, c);
      step();
    end
    line_in = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] f1, f2;
    vecs[0] = '{2'b10, 8'hA5, 8'h00, 16'hC528, 16'hFFFF, 16, 17};
    vecs[1] = '{2'b11, 8'h00, 8'h3C, 16'hE000, 16'hF802, 15, 18};
    vecs[2] = '{2'b01, 8'hFF, 8'h00, 16'hA000, 16'hFE00,  7,  8};
    vecs[3] = '{2'b10, 8'h3C, 8'h00, 16'hC1E0, 16'hFFFF, 16, 17};
    vecs[4] = '{2'b00, 8'h5A, 8'h00, 16'h8000, 16'hFE00,  7,  8};
    vecs[5] = '{2'b11, 8'h00, 8'h81, 16'hE000, 16'hF802, 15, 18};

    // Reset held with a pending request: nothing may start.
    reset = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b10;
    bus.req_data  = 8'hFF;
    bus.rsp_ready = 1'b1;
    line_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("rst%0d_out", k), {31'd0, line_out}, 32'd0);
      chk($sformatf("rst%0d_oe", k), {31'd0, line_oe}, 32'd1);
      chk($sformatf("rst%0d_busy", k), {31'd0, busy}, 32'd0);
      chk($sformatf("rst%0d_ready", k), {31'd0, bus.req_ready}, 32'd1);
      chk($sformatf("rst%0d_rspv", k), {31'd0, bus.rsp_valid}, 32'd0);
      chk($sformatf("rst%0d_rspd", k), {24'd0, bus.rsp_data}, 32'd0);
    end
    reset = 1'b1;
    bus.req_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("post_rst%0d_ready", k), {31'd0, bus.req_ready}, 32'd1);
      chk($sformatf("post_rst%0d_out", k), {31'd0, line_out}, 32'd0);
    end

    // Table of complete transactions, checked every cycle of the frame.
    foreach (vecs[i]) begin
      wait_ready();
      issue(vecs[i].op, vecs[i].data);
      for (int c = 1; c <= vecs[i].ready_cyc; c++) begin
        if (c <= vecs[i].nbits) begin
          chk($sformatf("v%0d_oe_c%0d", i, c), {31'd0, line_oe}, {31'd0, vecs[i].exp_oe[16-c]});
          if (vecs[i].exp_oe[16-c])
            chk($sformatf("v%0d_line_c%0d", i, c), {31'd0, line_out}, {31'd0, vecs[i].exp_line[16-c]});
        end
        chk($sformatf("v%0d_ready_c%0d", i, c), {31'd0, bus.req_ready}, {31'd0, (c == vecs[i].ready_cyc)});
        chk($sformatf("v%0d_busy_c%0d", i, c), {31'd0, busy}, {31'd0, (c != vecs[i].ready_cyc)});
        if (vecs[i].op == 2'b11 && c == 15) begin
          last_rd = vecs[i].rd;
          chk($sformatf("v%0d_rspv", i), {31'd0, bus.rsp_valid}, 32'd1);
          chk($sformatf("v%0d_rspd", i), {24'd0, bus.rsp_data}, {24'd0, last_rd});
        end
        if (c == vecs[i].ready_cyc)
          chk($sformatf("v%0d_rspd_hold", i), {24'd0, bus.rsp_data}, {24'd0, last_rd});
        line_in = rd_bit(vecs[i].rd, c);
        if (c < vecs[i].ready_cyc) step();
      end
      line_in = 1'b0;
    end

    // READ with the host stalling the response for 5 cycles.
    bus.rsp_ready = 1'b0;
    read_cycles(8'h96);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_rspv", k), {31'd0, bus.rsp_valid}, 32'd1);
      chk($sformatf("stall%0d_oe", k), {31'd0, line_oe}, 32'd1);
      chk($sformatf("stall%0d_line", k), {31'd0, line_out}, 32'd0);
      chk($sformatf("stall%0d_ready", k), {31'd0, bus.req_ready}, 32'd0);
      chk($sformatf("stall%0d_rspd", k), {24'd0, bus.rsp_data}, 32'h96);
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    chk("stall_rspv_drop", {31'd0, bus.rsp_valid}, 32'd0);
    chk("stall_hold1_ready", {31'd0, bus.req_ready}, 32'd0);
    step();
    chk("stall_hold2_ready", {31'd0, bus.req_ready}, 32'd0);
    step();
    chk("stall_idle_ready", {31'd0, bus.req_ready}, 32'd1);

    // UPDATE then RESET with req_valid held high throughout.
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    step();
    bus.req_op = 2'b00;
    for (int c = 1; c <= 7; c++) begin
      f1[7-c] = line_out;
      if (c == 1) chk("b2b_busy_ignored", {31'd0, bus.req_ready}, 32'd0);
      step();
    end
    chk("b2b_f1_ready_c8", {31'd0, bus.req_ready}, 32'd1);
    chk("b2b_f1_frame", {25'd0, f1}, 32'h50);
    step();
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      f2[7-c] = line_out;
      step();
    end
    chk("b2b_f2_ready_c8", {31'd0, bus.req_ready}, 32'd1);
    chk("b2b_f2_frame", {25'd0, f2}, 32'h40);

    // Reset during cycle 9 of a WRITE, then a normal READ.
    issue(2'b10, 8'hFF);
    for (int c = 1; c < 9; c++) step();
    reset = 1'b0;
    step();
    chk("abort_line", {31'd0, line_out}, 32'd0);
    chk("abort_oe", {31'd0, line_oe}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rspv", {31'd0, bus.rsp_valid}, 32'd0);
    reset = 1'b1;
    step();
    chk("abort_idle_ready", {31'd0, bus.req_ready}, 32'd1);
    read_cycles(8'h5A);
    chk("after_abort_rspv", {31'd0, bus.rsp_valid}, 32'd1);
    chk("after_abort_rspd", {24'd0, bus.rsp_data}, 32'h5A);
    for (int k = 0; k < 3; k++) step();
    chk("after_abort_ready", {31'd0, bus.req_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
